// File: rtl/rr_grant_arbiter_16_if.sv
// rtl/rr_grant_arbiter_16_if.sv - request/grant handshake bundle for the 16-way round-robin arbiter

interface rr_grant_arbiter_16_if #(
   parameter int N     = 16,
   parameter int IDX_W = 4
);
   // requester side
   logic [N-1:0]     req;
   // grant offer handshake
   logic             grant_valid;
   logic             grant_ready;
   logic [N-1:0]     grant_onehot;
   logic [IDX_W-1:0] grant_idx;
   // ownership tracking; release is a reserved word, hence release_pulse
   logic             busy;
   logic             release_pulse;

   // requesters / consumer drive the bundle
   modport master (
      output req,
      output grant_ready,
      output release_pulse,
      input  grant_valid,
      input  grant_onehot,
      input  grant_idx,
      input  busy
   );

   // the arbiter answers on the bundle
   modport slave (
      input  req,
      input  grant_ready,
      input  release_pulse,
      output grant_valid,
      output grant_onehot,
      output grant_idx,
      output busy
   );
endinterface

// File: rtl/rr_grant_arbiter_16.sv
// rtl/rr_grant_arbiter_16.sv - registered round-robin arbiter, one-hot grant held until release

module rr_grant_arbiter_16 #(
   parameter int N     = 16,
   parameter int IDX_W = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   rr_grant_arbiter_16_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_OFFER = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;

   logic [1:0]       r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [N-1:0]     r_onehot;
   logic [IDX_W-1:0] r_idx;
   logic             r_valid;
   logic             r_busy;

   logic             w_found;
   logic [IDX_W-1:0] w_win;
   logic [N-1:0]     w_win_onehot;

   // priority search starting just after the last accepted owner; the index
   // add wraps modulo N because N is a power of two, and k=N-1 lands on r_ptr
   always_comb begin
      logic [IDX_W-1:0] cand;
      w_found = 1'b0;
      w_win   = '0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = r_ptr + IDX_W'(k + 1);
         if (!w_found && bus.req[cand]) begin
            w_found = 1'b1;
            w_win   = cand;
         end
      end
   end

   assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;

   // grant FSM: search only in IDLE, freeze the offer, move the pointer on accept
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_ptr    <= IDX_W'(N - 1);
         r_onehot <= '0;
         r_idx    <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state  <= S_OFFER;
                  r_onehot <= w_win_onehot;
                  r_idx    <= w_win;
                  r_valid  <= 1'b1;
               end
            end
            S_OFFER: begin
               // release is deliberately not looked at here
               if (bus.grant_ready) begin
                  r_state <= S_BUSY;
                  r_ptr   <= r_idx;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_BUSY: begin
               if (bus.release_pulse) begin
                  r_state  <= S_IDLE;
                  r_onehot <= '0;
                  r_idx    <= '0;
                  r_busy   <= 1'b0;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_onehot <= '0;
               r_idx    <= '0;
               r_valid  <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant_valid  = r_valid;
   assign bus.grant_onehot = r_onehot;
   assign bus.grant_idx    = r_idx;
   assign bus.busy         = r_busy;

endmodule

// File: doc/rr_grant_arbiter_16.md
Name: rr_grant_arbiter_16

Overview:
- Sequential round-robin arbiter for a 16-way request vector.
- Produces a registered one-hot grant and its 4-bit encoded index, offered through a valid/ready handshake.
- The grant is held until the owner signals release.
- Sits between shared-resource requesters (refill/miss sources, bus masters) and the resource. It turns request vectors into one-hot grants, complementing the combinational index encoders and decoders elsewhere in the design.

Parameters:
N, 16, number of requesters (power of two)
IDX_W, 4, index width, log2(N)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
req  input  N  request vector, bit i = requester i
grant_valid  output  1  grant offered (OFFER state)
grant_ready  input  1  consumer accepts offered grant
grant_onehot  output  N  one-hot grant, zero in IDLE
grant_idx  output  IDX_W  encoded grant index, zero in IDLE
busy  output  1  accepted grant is held (BUSY state)
release  input  1  one-cycle pulse: owner done

Behaviour:
- Reset:
  - Clock is clk; reset is resetn, asynchronous and active-low.
  - While resetn=0: state=IDLE, grant_valid=0, grant_onehot=0, grant_idx=0, busy=0, ptr=N-1.
- State machine (registered): IDLE, OFFER, BUSY.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, the winner w is the first set bit at index (ptr+1+k) mod N, for k=0..N-1.
  - Register grant_onehot=1<<w and grant_idx=w; go to OFFER.
  - Latency: req sampled at edge t gives grant_valid=1 after edge t (one cycle).
- OFFER:
  - grant_valid=1. grant_onehot and grant_idx are stable and do not change while in OFFER.
  - req changes are ignored; a requester must hold req until it observes its grant.
  - grant_ready=1 at an edge: go to BUSY and set ptr<=grant_idx.
  - grant_ready=0: stay in OFFER.
  - release in OFFER is ignored, including when it coincides with grant_ready.
- BUSY:
  - busy=1, grant_valid=0; grant_onehot and grant_idx are held.
  - release=1 at an edge: go to IDLE, with grant_onehot=0 and grant_idx=0.
  - req is ignored.
- Turnaround: release at edge t gives IDLE after t. With req pending, grant_valid=1 after t+1 (minimum two cycles between grants).
- Fairness:
  - The last accepted index has lowest priority in the next search.
  - With all requesters continuously active, grants rotate 0,1,...,15,0 with no starvation.
  - ptr updates only on acceptance; an offered-but-not-yet-accepted grant does not move the pointer.
- Wrap-around: when ptr=15 the search starts at 0. When ptr=w and only req[w] is set, w wins again (k=N-1 case).
- Invariants:
  - grant_onehot has at most one bit set.
  - grant_idx always equals the encoded grant_onehot.
  - grant_valid and busy are never both 1.
- Reset mid-operation: asynchronous return to the reset values above from any state; the pointer is lost.
- All outputs come from registers; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset, then req=16'h0000 for 5 cycles -> grant_valid=0, busy=0, grant_onehot=0, grant_idx=0 throughout.
2. After reset, req=16'h0011 -> one cycle later grant_valid=1, grant_onehot=16'h0001, grant_idx=0. Then grant_ready=1 -> busy=1. Then release -> IDLE, and the next grant is 16'h0010 (idx 4).
3. req=16'hFFFF held, with ready and release each pulsed once per grant -> grant_idx sequence 0,1,2,...,15,0,1. Each grant starts two cycles after its release.
4. Offer idx 3 with grant_ready=0 for 4 cycles while req changes to 16'h8000 -> grant_onehot stays 16'h0008, grant_idx stays 3. Then grant_ready -> busy=1 with idx 3.
5. ptr=15, then req=16'h8001 -> idx 0 granted. Then ptr=0 with only req=16'h0001 -> idx 0 granted again (wrap case).
6. resetn driven low asynchronously mid-BUSY, between clock edges -> outputs go to zero immediately. After deassertion with req=16'h0006 -> idx 1 granted (ptr reset to 15).
